// File: rtl/wb_arbiter.sv
// Writeback-port arbiter: four sources share the register-file write port with multi-beat bursts.
// Define WB_ARB_PERF_EN to add the saturating beat_cnt / stall_cnt performance counters.
module wb_arbiter #(
  parameter int ADDR_W    = 4,
  parameter int PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [7:0]        req_len,
  input  logic [4*ADDR_W-1:0] req_addr,
  input  logic              wb_stall,
  output logic [3:0]        gnt,
  output logic [1:0]        wb_sel,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              wb_last,
  output logic              busy
`ifdef WB_ARB_PERF_EN
  ,
  output logic [15:0]       beat_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state_q;
  logic [1:0]          ptr_q;
  logic [1:0]          cnt_q;
  logic [1:0]          len_q;
  logic [3:0]          gnt_q;
  logic [1:0]          sel_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                last_q;
  logic                busy_q;

  logic                finish;
  logic                decide;
  logic [3:0]          cand;
  logic [1:0]          start;
  logic                win_vld_d;
  logic [1:0]          win_idx_d;
  logic [1:0]          idx;

  assign finish = (state_q == BURST) && we_q && last_q && !wb_stall;
  assign decide = (state_q == IDLE) || finish;
  // The source completing at this edge sits out the decision it triggers.
  assign cand   = req & ~(finish ? gnt_q : 4'b0000);
  assign start  = finish ? sel_q + 2'd1 : ptr_q;

  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = 2'd0;
    idx       = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = (PRIO_MODE == 1) ? 2'(k) : start + 2'(k);
      if (cand[idx]) begin
        win_vld_d = 1'b1;
        win_idx_d = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= 2'd0;
      len_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (decide) begin
      if (finish) ptr_q <= sel_q + 2'd1;
      if (win_vld_d) begin
        state_q <= BURST;
        gnt_q   <= 4'b0001 << win_idx_d;
        sel_q   <= win_idx_d;
        we_q    <= 1'b1;
        addr_q  <= req_addr[win_idx_d*ADDR_W +: ADDR_W];
        len_q   <= req_len[win_idx_d*2 +: 2];
        cnt_q   <= 2'd0;
        last_q  <= (req_len[win_idx_d*2 +: 2] == 2'd0);
        busy_q  <= 1'b1;
      end else begin
        state_q <= IDLE;
        gnt_q   <= 4'b0000;
        we_q    <= 1'b0;
        cnt_q   <= 2'd0;
        last_q  <= 1'b0;
        busy_q  <= 1'b0;
      end
    end else if (!wb_stall) begin
      addr_q <= addr_q + 1'b1;
      cnt_q  <= cnt_q + 2'd1;
      last_q <= ((cnt_q + 2'd1) == len_q);
    end
  end

  assign gnt     = gnt_q;
  assign wb_sel  = sel_q;
  assign wb_we   = we_q;
  assign wb_addr = addr_q;
  assign wb_last = last_q;
  assign busy    = busy_q;

`ifdef WB_ARB_PERF_EN
  logic [15:0] beat_cnt_q;
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q  <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      if (we_q && !wb_stall && beat_cnt_q != 16'hFFFF) beat_cnt_q <= beat_cnt_q + 16'd1;
      if (we_q && wb_stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign beat_cnt  = beat_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
